// File: rtl/tff_counter_if.sv
// rtl/tff_counter_if.sv - control and status bundle for the tff_counter phase timer
interface tff_counter_if #(
   parameter int WIDTH = 8
);
   logic             en;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] limit;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] q_n;
   logic [WIDTH-1:0] tog;
   logic             wrap;

   modport master (
      output en, up, load, load_val, limit,
      input  q, q_n, tog, wrap
   );

   modport slave (
      input  en, up, load, load_val, limit,
      output q, q_n, tog, wrap
   );
endinterface

// File: rtl/tff_counter.sv
// rtl/tff_counter.sv - up/down phase timer built from WIDTH T cells with load and wrap pulse
// Optional TFF_COUNTER_SATURATE_EN: hold at the terminal value instead of wrapping.
module tff_counter #(
   parameter int          WIDTH     = 8,
   parameter logic [31:0] RESET_VAL = 32'd0
) (
   input  logic         clk,
   input  logic         rst_n,
   tff_counter_if.slave bus
);
   localparam logic [WIDTH-1:0] LP_RST = RESET_VAL[WIDTH-1:0];
   localparam logic [WIDTH-1:0] LP_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_q_n;
   logic [WIDTH-1:0] r_tog;
   logic             r_wrap;

   logic [WIDTH-1:0] w_q_next;
   logic [WIDTH-1:0] w_t;
   logic             w_wrap_next;

   always_comb begin
      w_q_next    = r_q;
      w_wrap_next = 1'b0;
      if (bus.load) begin
         w_q_next = bus.load_val;
      end else if (bus.en) begin
         if (bus.up) begin
            if (r_q >= bus.limit) begin
`ifdef TFF_COUNTER_SATURATE_EN
               // Out-of-range q is pulled back to limit, which counts as entering it.
               w_q_next    = bus.limit;
               w_wrap_next = (r_q != bus.limit);
`else
               w_q_next    = '0;
               w_wrap_next = 1'b1;
`endif
            end else begin
               w_q_next = r_q + LP_ONE;
`ifdef TFF_COUNTER_SATURATE_EN
               w_wrap_next = ((r_q + LP_ONE) == bus.limit);
`endif
            end
         end else begin
            if (r_q == '0) begin
`ifdef TFF_COUNTER_SATURATE_EN
               w_q_next    = '0;
               w_wrap_next = 1'b0;
`else
               w_q_next    = bus.limit;
               w_wrap_next = 1'b1;
`endif
            end else begin
               w_q_next = r_q - LP_ONE;
`ifdef TFF_COUNTER_SATURATE_EN
               w_wrap_next = (r_q == LP_ONE);
`endif
            end
         end
      end
   end

   // Each bit is a T cell: its toggle enable is the difference between now and next.
   assign w_t = r_q ^ w_q_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q    <= LP_RST;
         r_q_n  <= ~LP_RST;
         r_tog  <= '0;
         r_wrap <= 1'b0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (w_t[i]) begin
               r_q[i]   <= ~r_q[i];
               r_q_n[i] <= ~r_q_n[i];
            end
         end
         r_tog  <= w_t;
         r_wrap <= w_wrap_next;
      end
   end

   assign bus.q    = r_q;
   assign bus.q_n  = r_q_n;
   assign bus.tog  = r_tog;
   assign bus.wrap = r_wrap;
endmodule

// File: tb/tb_tff_counter.sv
// tb/tb_tff_counter.sv - directed checks of tff_counter (WIDTH=8, RESET_VAL=5)
module tb_tff_counter;
   logic clk = 1'b0;
   logic rst_n;
   int   n_vec  = 0;
   int   n_miss = 0;

   tff_counter_if #(.WIDTH(8)) bus ();

   tff_counter #(.WIDTH(8), .RESET_VAL(32'd5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_miss++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_out(input string tag, input logic [7:0] eq, input logic ew);
      chk({tag, ".q"}, {24'd0, bus.q}, {24'd0, eq});
      chk({tag, ".q_n"}, {24'd0, bus.q_n}, {24'd0, ~eq});
      chk({tag, ".wrap"}, {31'd0, bus.wrap}, {31'd0, ew});
   endtask

   task automatic do_load(input logic [7:0] v);
      bus.load = 1'b1; bus.en = 1'b0; bus.load_val = v;
      step();
      bus.load = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      bus.en = 1'b0; bus.up = 1'b1; bus.load = 1'b0;
      bus.load_val = 8'd0; bus.limit = 8'd0;
      repeat (3) @(negedge clk);
      chk("rst.q", {24'd0, bus.q}, 32'h05);
      chk("rst.q_n", {24'd0, bus.q_n}, 32'hFA);
      chk("rst.tog", {24'd0, bus.tog}, 32'h00);
      chk("rst.wrap", {31'd0, bus.wrap}, 32'd0);

      rst_n = 1'b1;
      step();
      chk_out("hold0", 8'd5, 1'b0);
      step();
      chk_out("hold1", 8'd5, 1'b0);

      bus.limit = 8'd3; bus.up = 1'b1;
      do_load(8'd0);
      chk_out("upld", 8'd0, 1'b0);
      chk("upld.tog", {24'd0, bus.tog}, 32'h05);
      bus.en = 1'b1;
      step(); chk_out("up1", 8'd1, 1'b0);
      step(); chk_out("up2", 8'd2, 1'b0);
      chk("up2.tog", {24'd0, bus.tog}, 32'h03);
      step(); chk_out("up3", 8'd3, 1'b0);
      step(); chk_out("up0", 8'd0, 1'b1);
      chk("up0.tog", {24'd0, bus.tog}, 32'h03);
      step(); chk_out("up1b", 8'd1, 1'b0);

      bus.limit = 8'd9; bus.up = 1'b0;
      do_load(8'd2);
      chk_out("dnld", 8'd2, 1'b0);
      chk("dnld.tog", {24'd0, bus.tog}, 32'h03);
      bus.en = 1'b1;
      step(); chk_out("dn1", 8'd1, 1'b0);
      step(); chk_out("dn0", 8'd0, 1'b0);
      step(); chk_out("dn9", 8'd9, 1'b1);
      chk("dn9.tog", {24'd0, bus.tog}, 32'h09);
      step(); chk_out("dn8", 8'd8, 1'b0);

      bus.limit = 8'd10; bus.up = 1'b1;
      do_load(8'd7);
      chk_out("pri7", 8'd7, 1'b0);
      bus.load = 1'b1; bus.en = 1'b1; bus.load_val = 8'd20;
      step(); chk_out("pri20", 8'd20, 1'b0);
      bus.load = 1'b0;
      step(); chk_out("over", 8'd0, 1'b1);
      chk("over.tog", {24'd0, bus.tog}, 32'h14);

      bus.en = 1'b0;
      step(); chk_out("idle", 8'd0, 1'b0);
      chk("idle.tog", {24'd0, bus.tog}, 32'h00);

      bus.limit = 8'd0; bus.en = 1'b1; bus.up = 1'b1;
      step(); chk_out("lim0u1", 8'd0, 1'b1);
      step(); chk_out("lim0u2", 8'd0, 1'b1);
      bus.up = 1'b0;
      step(); chk_out("lim0d", 8'd0, 1'b1);

      bus.limit = 8'd10; bus.up = 1'b1;
      do_load(8'd5);
      bus.en = 1'b1;
      step(); chk_out("dir6", 8'd6, 1'b0);
      bus.up = 1'b0;
      step(); chk_out("dir5", 8'd5, 1'b0);

      bus.limit = 8'd6; bus.up = 1'b1;
      do_load(8'd6);
      chk_out("ar6", 8'd6, 1'b0);
      bus.en = 1'b1;
      step(); chk_out("arw", 8'd0, 1'b1);
      bus.en = 1'b0;
      do_load(8'd6);
      bus.en = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk_out("arst", 8'd5, 1'b0);
      chk("arst.tog", {24'd0, bus.tog}, 32'h00);
      @(negedge clk);
      chk_out("arst2", 8'd5, 1'b0);
      bus.en = 1'b0;
      step();
      step();
      bus.en = 1'b1; bus.up = 1'b1; bus.limit = 8'd6;
      step();
      step();
      chk_out("arwr", 8'd5, 1'b0);
      rst_n = 1'b1;
      step(); chk_out("arrel", 8'd6, 1'b0);
      step(); chk_out("arrelw", 8'd0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
